// File: rtl/inert_seq.sv
// ---------------------------------------------------------------------------
// inert_seq
//  Transaction sequencer for the gyro SPI link. After reset it waits out the
//  sensor power-up time, writes three configuration registers, then loops:
//  wait for the sensor data-ready interrupt, read the yaw low and high bytes,
//  and present the assembled 16-bit yaw with a one-cycle valid pulse.
//
//  Parameters
//   PWRUP_W  width of the power-up wait counter (wait = 2**PWRUP_W cycles)
//   TO_W     width of the per-transaction timeout counter (2**TO_W cycles)
//
//  Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   INT       in   1   sensor data-ready, asynchronous (synchronised here)
//   spi_done  in   1   SPI monarch done level
//   spi_rd    in   16  SPI monarch read data; [7:0] is the register value
//   spi_wrt   out  1   one-cycle pulse starting an SPI transaction
//   spi_cmd   out  16  {cmd/addr byte, data byte}, held until done rises
//   yaw       out  16  last assembled yaw {high, low}
//   vld       out  1   one-cycle pulse when yaw updates
//   err       out  1   sticky transaction-timeout flag
// ---------------------------------------------------------------------------
module inert_seq #(
    parameter int PWRUP_W = 16,
    parameter int TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [15:0] yaw,
    output logic        vld,
    output logic        err
);

    typedef enum logic [2:0] {
        PWRUP,
        CFG,
        CFG_W,
        INT_W,
        RDL,
        RDL_W,
        RDH,
        RDH_W
    } state_t;

    localparam logic [15:0] CMD_RD_YAW_L = 16'hA600;
    localparam logic [15:0] CMD_RD_YAW_H = 16'hA700;

    state_t             state_q, state_d;
    logic [PWRUP_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         low_byte_q, low_byte_d;
    logic [15:0]        yaw_q, yaw_d;
    logic [15:0]        spi_cmd_q, spi_cmd_d;
    logic               spi_wrt_q, spi_wrt_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               int_ff1_q, int_ff2_q;
    logic               done_ff_q;

    logic               done_rise;
    logic               in_wait;
    logic               timeout;

    // Configuration writes issued in order after power-up.
    function automatic logic [15:0] cfg_entry(input logic [1:0] i);
        case (i)
            2'd0:    return 16'h0D02;  // INT on gyro data-ready
            2'd1:    return 16'h1160;  // gyro 416 Hz
            default: return 16'h1440;  // rounding
        endcase
    endfunction

    // Only a rising edge of done completes a transfer, so a done level left
    // high by the previous transfer is never mistaken for completion.
    assign done_rise = spi_done & ~done_ff_q;
    assign in_wait   = (state_q == CFG_W) || (state_q == RDL_W) || (state_q == RDH_W);
    assign timeout   = in_wait && (&to_cnt_q);

    // State register plus all registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PWRUP;
            pwr_cnt_q  <= '0;
            to_cnt_q   <= '0;
            idx_q      <= 2'd0;
            low_byte_q <= 8'h00;
            yaw_q      <= 16'h0000;
            spi_cmd_q  <= 16'h0000;
            spi_wrt_q  <= 1'b0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            int_ff1_q  <= 1'b0;
            int_ff2_q  <= 1'b0;
            done_ff_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            to_cnt_q   <= to_cnt_d;
            idx_q      <= idx_d;
            low_byte_q <= low_byte_d;
            yaw_q      <= yaw_d;
            spi_cmd_q  <= spi_cmd_d;
            spi_wrt_q  <= spi_wrt_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            int_ff1_q  <= INT;
            int_ff2_q  <= int_ff1_q;
            done_ff_q  <= spi_done;
        end
    end

    // Next-state and datapath logic. A done rise wins over a timeout that
    // expires in the same cycle.
    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        idx_d      = idx_q;
        low_byte_d = low_byte_q;
        yaw_d      = yaw_q;
        vld_d      = 1'b0;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;

        // The timeout window restarts with every transaction launch.
        if (spi_wrt_q) begin
            to_cnt_d = '0;
        end else if (in_wait) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            PWRUP: begin
                if (&pwr_cnt_q) begin
                    state_d = CFG;
                    idx_d   = 2'd0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWRUP_W'(1);
                end
            end
            CFG: state_d = CFG_W;
            CFG_W: begin
                if (done_rise) begin
                    if (idx_q == 2'd2) begin
                        state_d = INT_W;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CFG;
                    end
                end else if (timeout) begin
                    // Remaining configuration writes are abandoned.
                    err_d   = 1'b1;
                    state_d = INT_W;
                end
            end
            INT_W: begin
                if (int_ff2_q) begin
                    state_d = RDL;
                end
            end
            RDL: state_d = RDL_W;
            RDL_W: begin
                if (done_rise) begin
                    low_byte_d = spi_rd[7:0];
                    state_d    = RDH;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = INT_W;
                end
            end
            RDH: state_d = RDH_W;
            RDH_W: begin
                if (done_rise) begin
                    yaw_d   = {spi_rd[7:0], low_byte_q};
                    vld_d   = 1'b1;
                    state_d = INT_W;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = INT_W;
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    // Output logic: launch states are decoded from the next state so that
    // the command and the write strobe register on the same edge that enters
    // the launch state. The command then holds through the wait state.
    always_comb begin
        spi_wrt_d = 1'b0;
        spi_cmd_d = spi_cmd_q;
        case (state_d)
            CFG: begin
                spi_wrt_d = 1'b1;
                spi_cmd_d = cfg_entry(idx_d);
            end
            RDL: begin
                spi_wrt_d = 1'b1;
                spi_cmd_d = CMD_RD_YAW_L;
            end
            RDH: begin
                spi_wrt_d = 1'b1;
                spi_cmd_d = CMD_RD_YAW_H;
            end
            default: begin
                spi_wrt_d = 1'b0;
                spi_cmd_d = spi_cmd_q;
            end
        endcase
    end

    assign spi_wrt = spi_wrt_q;
    assign spi_cmd = spi_cmd_q;
    assign yaw     = yaw_q;
    assign vld     = vld_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inert_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_seq
//  Self-checking bench for inert_seq. A behavioural SPI monarch answers each
//  transaction after a random latency with random register data; the bench
//  keeps the expected command order and the expected yaw words it handed out
//  and compares them against what the sequencer issues and reports.
// ---------------------------------------------------------------------------
module tb_inert_seq;

    localparam int          PWRUP_W = 4;
    localparam int          TO_W    = 4;
    localparam logic [15:0] CMD_RDL = 16'hA600;
    localparam logic [15:0] CMD_RDH = 16'hA700;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_in;
    logic        spi_done;
    logic [15:0] spi_rd;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [15:0] yaw;
    logic        vld;
    logic        err;

    inert_seq #(
        .PWRUP_W (PWRUP_W),
        .TO_W    (TO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .INT      (int_in),
        .spi_done (spi_done),
        .spi_rd   (spi_rd),
        .spi_wrt  (spi_wrt),
        .spi_cmd  (spi_cmd),
        .yaw      (yaw),
        .vld      (vld),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SPI model and reference state
    logic [15:0] exp_yaw_q[$];
    logic [15:0] cur_cmd;
    logic [15:0] pair_yaw;
    logic [15:0] forced_yaw;
    int          n_cmd = 0;
    int          n_vld = 0;
    int          hold = 0;
    int          lat = 0;
    bit          busy = 1'b0;
    bit          prev_wrt = 1'b0;
    bit          prev_vld = 1'b0;
    bit          forced_valid = 1'b0;
    bit          stale_next = 1'b0;
    bit          stale_active = 1'b0;
    bit          stale_released = 1'b0;
    bit          nodone_next = 1'b0;
    bit          slow_next = 1'b0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected command order: three config writes, then alternating reads.
    function automatic logic [15:0] expected_cmd(input int n);
        if (n == 0) return 16'h0D02;
        if (n == 1) return 16'h1160;
        if (n == 2) return 16'h1440;
        return (((n - 3) % 2) == 0) ? CMD_RDL : CMD_RDH;
    endfunction

    // Behavioural SPI monarch plus output monitor, evaluated away from the
    // active edge.
    always @(negedge clk) begin
        if (rst) begin
            spi_done     = 1'b1;
            spi_rd       = 16'h0000;
            busy         = 1'b0;
            stale_active = 1'b0;
            n_cmd        = 0;
            prev_wrt     = 1'b0;
            prev_vld     = 1'b0;
            exp_yaw_q.delete();
        end else begin
            if (vld) begin
                checkOutput("vld_width", 16'(prev_vld), 16'd0);
                if (exp_yaw_q.size() == 0) begin
                    checkOutput("vld_unexpected", 16'd1, 16'd0);
                end else begin
                    checkOutput("yaw_value", yaw, exp_yaw_q.pop_front());
                end
                n_vld++;
            end
            if (spi_wrt) begin
                checkOutput("wrt_width", 16'(prev_wrt), 16'd0);
                checkOutput("cmd_order", spi_cmd, expected_cmd(n_cmd));
                n_cmd++;
                cur_cmd = spi_cmd;
                busy    = 1'b1;
                hold    = 0;
                lat     = $urandom_range(1, 6);
                if (spi_cmd == CMD_RDL && stale_next) begin
                    stale_next   = 1'b0;
                    stale_active = 1'b1;
                    hold         = 5;
                    lat          = 2;
                end
                if (spi_cmd == CMD_RDH && nodone_next) begin
                    nodone_next = 1'b0;
                    busy        = 1'b0;
                end
                if (spi_cmd == CMD_RDH && slow_next) begin
                    slow_next = 1'b0;
                    lat       = 10;
                end
                if (hold == 0) spi_done = 1'b0;
            end else if (busy) begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) spi_done = 1'b0;
                end else if (lat > 0) begin
                    lat--;
                end else begin
                    checkOutput("cmd_hold", spi_cmd, cur_cmd);
                    if (cur_cmd == CMD_RDL) begin
                        pair_yaw     = forced_valid ? forced_yaw : 16'($urandom);
                        forced_valid = 1'b0;
                        spi_rd       = {8'($urandom), pair_yaw[7:0]};
                    end else if (cur_cmd == CMD_RDH) begin
                        spi_rd = {8'($urandom), pair_yaw[15:8]};
                        exp_yaw_q.push_back(pair_yaw);
                    end else begin
                        spi_rd = 16'($urandom);
                    end
                    if (stale_active) begin
                        stale_released = 1'b1;
                        stale_active   = 1'b0;
                    end
                    spi_done = 1'b1;
                    busy     = 1'b0;
                end
            end
            prev_wrt = spi_wrt;
            prev_vld = vld;
        end
    end

    // One-cycle data-ready pulse after a gap.
    task automatic applyStimulus(input int gap);
        repeat (gap) @(negedge clk);
        int_in = 1'b1;
        @(negedge clk);
        int_in = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wrt"}, 16'(spi_wrt), 16'd0);
        checkOutput({tag, "_cmd"}, spi_cmd, 16'h0000);
        checkOutput({tag, "_yaw"}, yaw, 16'h0000);
        checkOutput({tag, "_vld"}, 16'(vld), 16'd0);
        checkOutput({tag, "_err"}, 16'(err), 16'd0);
    endtask

    // Releases reset and checks the power-up wait length and first command.
    task automatic releaseAndCheckPowerup(input string tag);
        int cyc;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!spi_wrt && cyc < 60);
        checkOutput({tag, "_pwrup_cycles"}, 16'(cyc), 16'd16);
        checkOutput({tag, "_first_cmd"}, spi_cmd, 16'h0D02);
    endtask

    task automatic waitIdle(input int target, input int budget, input string tag);
        int c = 0;
        while ((n_cmd < target || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 16'(n_cmd >= target && !busy), 16'd1);
    endtask

    task automatic waitVld(input int target, input int budget, input string tag);
        int c = 0;
        while (n_vld < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 16'(n_vld >= target), 16'd1);
    endtask

    task automatic waitCmd(input logic [15:0] cmd, input int budget, input string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(spi_wrt && spi_cmd == cmd) && c < budget);
        checkOutput(tag, 16'(spi_wrt && spi_cmd == cmd), 16'd1);
    endtask

    initial begin
        logic [15:0] yaw_before;
        int          vld_before;
        int          cnt;

        rst      = 1'b1;
        int_in   = 1'b0;
        spi_done = 1'b1;
        spi_rd   = 16'h0000;

        // Reset state, power-up wait and configuration sequence
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        releaseAndCheckPowerup("boot");
        waitIdle(3, 200, "cfg_complete");
        checkOutput("cfg_no_err", 16'(err), 16'd0);

        // Single INT pulse with known register values
        forced_yaw   = 16'h1234;
        forced_valid = 1'b1;
        applyStimulus(2);
        waitVld(n_vld + 1, 200, "t2_vld_seen");
        checkOutput("t2_yaw", yaw, 16'h1234);

        // Randomised read pairs with random INT spacing
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom_range(0, 5));
            waitVld(n_vld + 1, 200, "rand_pair_vld");
        end

        // Stale done level held high into the low-byte wait
        stale_next     = 1'b1;
        stale_released = 1'b0;
        applyStimulus(2);
        waitCmd(CMD_RDH, 200, "t3_rdh_issued");
        checkOutput("t3_waited_for_rise", 16'(stale_released), 16'd1);
        waitVld(n_vld + 1, 200, "t3_vld_seen");

        // High-byte read never completes: timeout
        repeat (3) @(negedge clk);
        yaw_before  = yaw;
        vld_before  = n_vld;
        nodone_next = 1'b1;
        applyStimulus(2);
        waitCmd(CMD_RDH, 200, "t4_rdh_issued");
        cnt = 0;
        while (!err && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t4_timeout_cycles", 16'(cnt), 16'd17);
        checkOutput("t4_yaw_held", yaw, yaw_before);
        checkOutput("t4_no_vld", 16'(n_vld), 16'(vld_before));
        applyStimulus(3);
        waitVld(n_vld + 1, 200, "t4_recovery_vld");
        checkOutput("t4_err_sticky", 16'(err), 16'd1);

        // INT held high: back-to-back read pairs
        vld_before = n_vld;
        int_in     = 1'b1;
        waitVld(vld_before + 4, 400, "t5_back_to_back");
        int_in = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("t5_all_pairs_reported", 16'(exp_yaw_q.size()), 16'd0);

        // Reset during the high-byte wait
        slow_next = 1'b1;
        applyStimulus(2);
        waitCmd(CMD_RDH, 200, "t6_rdh_issued");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkResetOutputs("midrst");
        @(negedge clk);
        releaseAndCheckPowerup("replay");
        waitIdle(3, 200, "replay_cfg_complete");
        applyStimulus(2);
        waitVld(n_vld + 1, 200, "replay_vld");
        repeat (5) @(negedge clk);
        checkOutput("final_queue_empty", 16'(exp_yaw_q.size()), 16'd0);
        checkOutput("final_err_clear", 16'(err), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
